// File: rtl/formation_pkg.sv
// Shared types and helpers for the enemy formation engine.
package formation_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLIDE = 2'd1,
        MARCH   = 2'd2,
        DRAW    = 2'd3
    } state_t;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 10;

    // Position of cell idx along one axis; wraps at CW bits.
    function automatic logic [CW-1:0] cell_pos(input logic [CW-1:0] base,
                                               input int idx,
                                               input int pitch);
        return base + CW'(idx * pitch);
    endfunction

endpackage

// File: rtl/formation_hit_finder.sv
// Combinational priority encoder: lowest alive cell whose hit-box contains the bullet.
// Zero latency; no flow control.
module formation_hit_finder
    import formation_pkg::*;
#(
    parameter int ROWS    = 2,
    parameter int COLS    = 9,
    parameter int X_PITCH = 28,
    parameter int Y_PITCH = 25,
    parameter int SPR_W   = 20,
    parameter int SPR_H   = 16
) (
    input  logic                 bvalid_i,
    input  logic [XW-1:0]        bx_i,
    input  logic [YW-1:0]        by_i,
    input  logic [XW-1:0]        anchor_x_i,
    input  logic [YW-1:0]        anchor_y_i,
    input  logic [ROWS*COLS-1:0] alive_i,
    output logic                 hit_o,
    output logic [7:0]           k_o
);

    logic [CW-1:0] bx10, by10;

    assign bx10 = {1'b0, bx_i};
    assign by10 = {2'b0, by_i};

    // Scan from the highest index down so the lowest matching cell wins.
    always_comb begin
        hit_o = 1'b0;
        k_o   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                if (bvalid_i && alive_i[r*COLS+c] &&
                    bx10 >= cell_pos({1'b0, anchor_x_i}, c, X_PITCH) &&
                    bx10 <= cell_pos({1'b0, anchor_x_i}, c, X_PITCH) + CW'(SPR_W) &&
                    by10 >= cell_pos({2'b0, anchor_y_i}, r, Y_PITCH) &&
                    by10 <= cell_pos({2'b0, anchor_y_i}, r, Y_PITCH) + CW'(SPR_H)) begin
                    hit_o = 1'b1;
                    k_o   = 8'(r*COLS + c);
                end
            end
        end
    end

endmodule

// File: rtl/formation_engine.sv
// Enemy formation: alive bitmap, marching anchor, per-bullet collision, score, sprite scan.
// Tick service NUM_BULLETS+2 cycles; sprite cells held until spr_ready, one per cycle.
// FORMATION_SPEEDUP_EN: march threshold shrinks by one every four kills (min 1).
module formation_engine
    import formation_pkg::*;
#(
    parameter int ROWS        = 2,
    parameter int COLS        = 9,
    parameter int NUM_BULLETS = 2,
    parameter int X_PITCH     = 28,
    parameter int Y_PITCH     = 25,
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 16,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 60,
    parameter int Y_START     = 10,
    parameter int Y_STEP      = 20,
    parameter int Y_LIMIT     = 200,
    parameter int MARCH_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      tick,
    input  logic [NUM_BULLETS-1:0]    bullet_valid,
    input  logic [9*NUM_BULLETS-1:0]  bullet_x,
    input  logic [8*NUM_BULLETS-1:0]  bullet_y,
    output logic [NUM_BULLETS-1:0]    hit,
    input  logic                      draw_req,
    output logic                      spr_valid,
    input  logic                      spr_ready,
    output logic [XW-1:0]             spr_x,
    output logic [YW-1:0]             spr_y,
    output logic                      spr_alive,
    output logic                      spr_last,
    output logic                      busy,
    output logic [XW-1:0]             anchor_x,
    output logic [YW-1:0]             anchor_y,
    output logic [7:0]                score,
    output logic                      all_dead,
    output logic                      invaded
);

    localparam int N  = ROWS * COLS;
    localparam int BW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    state_t                 state_q, state_d;
    logic [N-1:0]           alive_q, alive_d;
    logic [XW-1:0]          ax_q, ax_d;
    logic [YW-1:0]          ay_q, ay_d;
    logic                   dir_left_q, dir_left_d;
    logic [7:0]             div_q, div_d, score_q, score_d;
    logic [7:0]             k_q, k_d, c_q, c_d, r_q, r_d;
    logic [BW-1:0]          bidx_q, bidx_d;
    logic [NUM_BULLETS-1:0] hit_q, hit_d;
    logic                   tick_pend_q, tick_pend_d, draw_pend_q, draw_pend_d;

    logic          cur_vld, hf_hit, tick_take, draw_take, last_b, last_k;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [7:0]    hf_k, thr;
    logic [8:0]    ysum;
    logic [YW-1:0] ay_step;

    always_comb begin
        cur_vld = 1'b0;
        cur_x   = '0;
        cur_y   = '0;
        for (int b = 0; b < NUM_BULLETS; b++) begin
            if (BW'(b) == bidx_q) begin
                cur_vld = bullet_valid[b];
                cur_x   = bullet_x[9*b +: 9];
                cur_y   = bullet_y[8*b +: 8];
            end
        end
    end

    formation_hit_finder #(
        .ROWS(ROWS), .COLS(COLS), .X_PITCH(X_PITCH), .Y_PITCH(Y_PITCH),
        .SPR_W(SPR_W), .SPR_H(SPR_H)
    ) u_hit_finder (
        .bvalid_i  (cur_vld),
        .bx_i      (cur_x),
        .by_i      (cur_y),
        .anchor_x_i(ax_q),
        .anchor_y_i(ay_q),
        .alive_i   (alive_q),
        .hit_o     (hf_hit),
        .k_o       (hf_k)
    );

`ifdef FORMATION_SPEEDUP_EN
    logic [7:0] kills_div4;
    assign kills_div4 = score_q >> 2;
    assign thr = (kills_div4 >= 8'(MARCH_DIV)) ? 8'd1 : 8'(MARCH_DIV) - kills_div4;
`else
    assign thr = 8'(MARCH_DIV);
`endif

    assign tick_take = (state_q == IDLE) && (tick || tick_pend_q);
    assign draw_take = (state_q == IDLE) && !tick_take && (draw_req || draw_pend_q);
    assign last_b    = (bidx_q == BW'(NUM_BULLETS - 1));
    assign last_k    = (k_q == 8'(N - 1));
    assign ysum      = {1'b0, ay_q} + 9'(Y_STEP);
    assign ay_step   = ysum[8] ? 8'hFF : ysum[7:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            alive_q     <= '1;
            ax_q        <= XW'(X_MIN);
            ay_q        <= YW'(Y_START);
            dir_left_q  <= 1'b0;
            div_q       <= '0;
            score_q     <= '0;
            k_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            bidx_q      <= '0;
            hit_q       <= '0;
            tick_pend_q <= 1'b0;
            draw_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alive_q     <= alive_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            dir_left_q  <= dir_left_d;
            div_q       <= div_d;
            score_q     <= score_d;
            k_q         <= k_d;
            c_q         <= c_d;
            r_q         <= r_d;
            bidx_q      <= bidx_d;
            hit_q       <= hit_d;
            tick_pend_q <= tick_pend_d;
            draw_pend_q <= draw_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_take) state_d = COLLIDE;
                     else if (draw_take) state_d = DRAW;
            COLLIDE: if (last_b) state_d = MARCH;
            MARCH:   state_d = IDLE;
            DRAW:    if (spr_ready && last_k) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alive_d     = alive_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        dir_left_d  = dir_left_q;
        div_d       = div_q;
        score_d     = score_q;
        k_d         = k_q;
        c_d         = c_q;
        r_d         = r_q;
        bidx_d      = bidx_q;
        hit_d       = '0;
        tick_pend_d = tick_take ? 1'b0 : (tick_pend_q | tick);
        draw_pend_d = draw_take ? 1'b0 : (draw_pend_q | draw_req);
        case (state_q)
            IDLE: begin
                bidx_d = '0;
                k_d    = '0;
                c_d    = '0;
                r_d    = '0;
            end
            COLLIDE: begin
                // Kill lands on this edge so later bullets in the tick no longer see it.
                if (hf_hit) begin
                    for (int k = 0; k < N; k++)
                        if (8'(k) == hf_k) alive_d[k] = 1'b0;
                    for (int b = 0; b < NUM_BULLETS; b++)
                        if (BW'(b) == bidx_q) hit_d[b] = 1'b1;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end
                bidx_d = bidx_q + BW'(1);
            end
            MARCH: begin
                if (div_q >= thr - 8'd1) begin
                    div_d = '0;
                    if (!dir_left_q) begin
                        if (ax_q == XW'(X_MAX)) begin
                            dir_left_d = 1'b1;
                            ay_d       = ay_step;
                        end else begin
                            ax_d = ax_q + XW'(1);
                        end
                    end else begin
                        if (ax_q == XW'(X_MIN)) begin
                            dir_left_d = 1'b0;
                            ay_d       = ay_step;
                        end else begin
                            ax_d = ax_q - XW'(1);
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DRAW: begin
                if (spr_ready && !last_k) begin
                    k_d = k_q + 8'd1;
                    if (c_q == 8'(COLS - 1)) begin
                        c_d = '0;
                        r_d = r_q + 8'd1;
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [CW-1:0] spr_y10;
    assign spr_y10 = cell_pos({2'b0, ay_q}, int'(r_q), Y_PITCH);

    assign spr_valid = (state_q == DRAW);
    assign spr_x     = XW'(cell_pos({1'b0, ax_q}, int'(c_q), X_PITCH));
    assign spr_y     = YW'(spr_y10);
    assign spr_alive = (|(alive_q & (N'(1) << k_q))) && (spr_y10 < CW'(Y_LIMIT));
    assign spr_last  = last_k;
    assign busy      = (state_q != IDLE);
    assign anchor_x  = ax_q;
    assign anchor_y  = ay_q;
    assign score     = score_q;
    assign hit       = hit_q;
    assign all_dead  = ~|alive_q;

    always_comb begin
        invaded = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (alive_q[r*COLS+c] &&
                    cell_pos({2'b0, ay_q}, r, Y_PITCH) + CW'(SPR_H) >= CW'(Y_LIMIT))
                    invaded = 1'b1;
    end

endmodule

// File: tb/tb_formation_engine.sv
// Directed self-checking bench for formation_engine with default parameters.
module tb_formation_engine;

    logic        clk, resetn, tick, draw_req, spr_ready;
    logic [1:0]  bullet_valid;
    logic [17:0] bullet_x;
    logic [15:0] bullet_y;
    logic [1:0]  hit;
    logic        spr_valid, spr_alive, spr_last, busy, all_dead, invaded;
    logic [8:0]  spr_x, anchor_x;
    logic [7:0]  spr_y, anchor_y, score;

    int passed = 0;
    int total  = 0;

`ifdef FORMATION_SPEEDUP_EN
    localparam int EXP_PERIOD = 3;
`else
    localparam int EXP_PERIOD = 4;
`endif

    formation_engine dut (
        .clk(clk), .resetn(resetn), .tick(tick),
        .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .hit(hit), .draw_req(draw_req), .spr_valid(spr_valid), .spr_ready(spr_ready),
        .spr_x(spr_x), .spr_y(spr_y), .spr_alive(spr_alive), .spr_last(spr_last),
        .busy(busy), .anchor_x(anchor_x), .anchor_y(anchor_y), .score(score),
        .all_dead(all_dead), .invaded(invaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_bullets(input logic [1:0] v, input int x0, input int y0,
                               input int x1, input int y1);
        bullet_valid = v;
        bullet_x     = {9'(x1), 9'(x0)};
        bullet_y     = {8'(y1), 8'(y0)};
    endtask

    // One tick, then wait for the engine to return to idle, collecting hit pulses.
    task automatic do_tick(output int pulses, output logic [1:0] hit_or);
        bit done;
        done   = 1'b0;
        pulses = 0;
        hit_or = '0;
        @(negedge clk);
        tick = 1'b1;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (hit != 2'b00) begin
                pulses++;
                hit_or |= hit;
            end
            if (!busy) done = 1'b1;
        end
        check("tick_done", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int         p, n, t, moves, first_t, per;
        logic [1:0] h;
        logic [8:0] last_x;

        resetn = 1'b0; tick = 1'b0; draw_req = 1'b0; spr_ready = 1'b0;
        set_bullets(2'b00, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        check("rst_anchor_x", 32'(anchor_x), 32'd8);
        check("rst_anchor_y", 32'(anchor_y), 32'd10);
        check("rst_all_dead", 32'(all_dead), 32'd0);
        check("rst_score",    32'(score),    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_spr_valid", 32'(spr_valid), 32'd0);
        check("rst_hit",      32'(hit),      32'd0);
        check("rst_invaded",  32'(invaded),  32'd0);

        // March: one step every 4 ticks
        repeat (3) do_tick(p, h);
        check("march_3ticks_x", 32'(anchor_x), 32'd8);
        do_tick(p, h);
        check("march_4ticks_x", 32'(anchor_x), 32'd9);
        for (int i = 0; i < 300 && anchor_x != 9'd60; i++) do_tick(p, h);
        check("march_reach_x", 32'(anchor_x), 32'd60);
        check("march_reach_y", 32'(anchor_y), 32'd10);
        repeat (4) do_tick(p, h);
        check("bounce_x", 32'(anchor_x), 32'd60);
        check("bounce_y", 32'(anchor_y), 32'd30);
        repeat (4) do_tick(p, h);
        check("left_x", 32'(anchor_x), 32'd59);
        check("left_y", 32'(anchor_y), 32'd30);

        pulse_reset();
        check("rerst_anchor_x", 32'(anchor_x), 32'd8);

        // Single bullet kills cell 0, then finds nothing
        set_bullets(2'b01, 10, 12, 0, 0);
        do_tick(p, h);
        check("kill0_pulses", 32'(p), 32'd1);
        check("kill0_hit",    32'(h), 32'd1);
        check("kill0_score",  32'(score), 32'd1);
        do_tick(p, h);
        check("rekill0_pulses", 32'(p), 32'd0);
        check("rekill0_score",  32'(score), 32'd1);

        // Both bullets on cell 1: only bullet 0 scores
        set_bullets(2'b11, 40, 20, 40, 20);
        do_tick(p, h);
        check("dual_hit",    32'(h), 32'd1);
        check("dual_pulses", 32'(p), 32'd1);
        check("dual_score",  32'(score), 32'd2);
        set_bullets(2'b00, 0, 0, 0, 0);

        // Sprite scan with toggling ready and a tick arriving mid-scan
        @(negedge clk);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        check("draw_first_valid", 32'(spr_valid), 32'd1);
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 18; cyc++) begin
            spr_ready = (cyc % 2 == 0);
            tick      = (cyc == 6);
            #1;
            if (spr_valid && spr_ready) begin
                check("scan_x",     32'(spr_x),     32'(8 + 28 * (n % 9)));
                check("scan_y",     32'(spr_y),     32'(10 + 25 * (n / 9)));
                check("scan_alive", 32'(spr_alive), 32'(n >= 2));
                check("scan_last",  32'(spr_last),  32'(n == 17));
                n++;
            end
            @(negedge clk);
        end
        tick = 1'b0;
        spr_ready = 1'b0;
        check("scan_count", 32'(n), 32'd18);
        repeat (8) @(negedge clk);
        check("pend_tick_x",    32'(anchor_x), 32'd9);
        check("pend_tick_busy", 32'(busy),     32'd0);
        check("post_scan_valid", 32'(spr_valid), 32'd0);

        // Reset in the middle of a scan
        @(negedge clk);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        @(negedge clk);
        check("midscan_valid", 32'(spr_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_scan_valid", 32'(spr_valid), 32'd0);
        check("rst_scan_busy",  32'(busy),      32'd0);
        resetn = 1'b1;
        check("rst_scan_score", 32'(score),    32'd0);
        check("rst_scan_x",     32'(anchor_x), 32'd8);

        // Kill four enemies, then measure march period
        set_bullets(2'b11, 10, 12, 40, 12);
        do_tick(p, h);
        check("k4a_hit", 32'(h), 32'd3);
        set_bullets(2'b11, 70, 12, 100, 12);
        do_tick(p, h);
        check("k4b_hit", 32'(h), 32'd3);
        check("k4_score", 32'(score), 32'd4);
        set_bullets(2'b00, 0, 0, 0, 0);
        t = 0; moves = 0; first_t = 0; per = 0;
        last_x = anchor_x;
        for (int i = 0; i < 12 && moves < 2; i++) begin
            do_tick(p, h);
            t++;
            if (anchor_x != last_x) begin
                moves++;
                last_x = anchor_x;
                if (moves == 1) first_t = t;
                else per = t - first_t;
            end
        end
        check("march_period", 32'(per), 32'(EXP_PERIOD));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
